fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the 16-bit processor: owns the PC, drives a variable-latency instruction-memory request/acknowledge port, and presents one registered instruction per cycle to decode. Sits directly upstream of decode/register-file/ALU (which consumes `if_instr`/`if_pc`) and accepts redirects from execute. It also detects HALT and stops fetching.

## Interface
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `NOP_INSTR`, 16'h0800: value of `if_instr` when nothing is valid.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  16  byte address of the requested instruction.
- `imem_ack`  in  1  memory has returned data this cycle; may assert in the first cycle of `imem_req`.
- `imem_rdata`  in  16  instruction word; valid only when `imem_ack`=1.
- `redirect_valid`  in  1  execute resolved a taken branch/jump.
- `redirect_pc`  in  16  new fetch target.
- `stall`  in  1  decode cannot accept this cycle.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a live instruction.
- `if_instr`  out  16  fetched instruction.
- `if_pc`  out  16  address of `if_instr`.
- `if_pc_plus2`  out  16  `if_pc`+2, mod 2^16.
- `halted`  out  1  HALT was accepted by decode; fetch stopped.

## Operation
- States: FETCH, DRAIN, HALT.
- Transfer to decode: `if_valid & ~stall`. `stall` is ignored while `if_valid`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc, except that without skid the request drops while `if_valid & stall`.
  - `imem_addr` is held stable until `imem_ack`.
  - On ack: the instruction is loaded into the output register (or the skid buffer, see Configuration) with pc, and pc <= pc+2 (wraps 16'hFFFE to 16'h0000).
- HALT detect: a captured instruction with `[15:11]`=5'b00000 is delivered normally. No further requests are made; the FSM enters HALT. `halted` rises the cycle after the HALT instruction transfers.
- Redirect (highest priority, any state):
  - Next cycle: `if_valid`=0, skid cleared, pc <= `redirect_pc`, `halted`=0.
  - If an unacked request is outstanding, the FSM goes to DRAIN. DRAIN keeps `imem_req`=1 with the old address until ack, discards the data, then returns to FETCH at the redirect target.
  - Ack in the same cycle as the redirect: data discarded, no DRAIN, go directly to FETCH.
  - Redirect in HALT: resume FETCH.
  - Redirect during DRAIN: update the target and remain in DRAIN.
- HALT: `imem_req`=0; the outputs drain as normal.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_instr`=NOP_INSTR, `if_pc`=0, `if_pc_plus2`=2.
  - `halted`=0, state FETCH.
- Reset mid-operation discards any outstanding request; memory must tolerate an abandoned request.
- First request: the cycle after `rst` falls.
- Latency: request cycle with ack -> `if_valid` next cycle.
- Zero-wait memory with no stall sustains one instruction per cycle.
- N wait cycles add N cycles per instruction.
- All outputs except `imem_req` are registered.
- `imem_req` is combinational from state, skid occupancy, `if_valid` and `stall`. It does not depend on `imem_ack`.

## Configuration
- `FETCH_SKID_EN` defined: adds a one-entry skid buffer.
  - The request stays asserted while the output is stalled, and an ack lands in the skid.
  - The request drops only when the skid is full.
  - On transfer, the skid moves to the output in the same edge.
  - Throughput after a one-cycle stall: no bubble.
- Undefined: no skid. The request is gated by `~(if_valid & stall)`, and one bubble follows each stall release.

## Structure
- `proc_pkg` holds:
  - `OP_HALT`=5'b00000, `OP_NOP`=5'b00001;
  - `INSTR_W`=16, `PC_INC`=2;
  - the fetch state enum (FETCH, DRAIN, HALT).
- Sub-module `fetch_skid_buf`: one-entry valid/instr/pc buffer with load, pop and flush. It is instantiated only under `FETCH_SKID_EN`.

## Test plan
- Reset, zero-wait memory holding c010@0, c101@2, d828@4:
  - `if_instr` c010/c101/d828 on consecutive cycles;
  - `if_pc` 0/2/4;
  - `imem_addr` 0 in the first cycle after reset.
- Memory with 3 wait states: each instruction `if_valid` 4 cycles apart; `imem_addr` stable throughout each wait.
- Stall for 2 cycles while `if_instr`=c101:
  - output held;
  - d828 follows with no bubble under `FETCH_SKID_EN`, with one bubble without it.
- Redirect to 16'h0040 while a request to 6 is waiting: DRAIN until ack, data dropped, next `imem_addr`=0040, `if_valid`=0 meanwhile.
- HALT 16'h0000 at address 8:
  - delivered with `if_pc`=8;
  - `imem_req` stays low afterwards;
  - `halted`=1 after the transfer;
  - redirect to 0 resumes fetch.
- Assert `rst` for one cycle during a wait state: all outputs return to reset values, and the next request goes to RESET_PC.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants, opcodes and fetch FSM encoding for the 16-bit processor.
package proc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam logic [15:0] PC_INC  = 16'd2;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port; master is the fetch stage.
interface fetch_stage_if;
  import proc_pkg::*;

  logic               imem_req;
  logic [15:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry valid/instr/pc holding buffer used by fetch when FETCH_SKID_EN is defined.
module fetch_skid_buf
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [15:0]        in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [15:0]        pc
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, variable-latency imem port, registered decode output, HALT.
// Optional one-entry skid buffer enabled by defining FETCH_SKID_EN.
module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [15:0]        RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'b0}
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  input  logic               stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [15:0]        if_pc,
  output logic [15:0]        if_pc_plus2,
  output logic               halted
);

  fetch_state_e state;
  logic [15:0]  pc;
  logic [15:0]  drain_pc;

  logic               mem_ack;
  logic               fetch_ack;
  logic               transfer;
  logic               fetch_gate;
  logic               load_out;
  logic [INSTR_W-1:0] load_instr;
  logic [15:0]        load_pc;

  assign transfer  = if_valid & ~stall;
  assign mem_ack   = imem.imem_ack & imem.imem_req;
  assign fetch_ack = mem_ack & (state == FETCH) & ~redirect_valid;

`ifdef FETCH_SKID_EN
  logic               skid_valid;
  logic               skid_load;
  logic               skid_pop;
  logic               out_free;
  logic [INSTR_W-1:0] skid_instr;
  logic [15:0]        skid_pc;

  // Request stays up while decode stalls; an ack then parks in the skid, which
  // refills the output on the same edge the stalled instruction transfers.
  assign out_free   = ~if_valid | ~stall;
  assign skid_pop   = skid_valid & transfer;
  assign skid_load  = fetch_ack & ~out_free;
  assign load_out   = skid_pop | (fetch_ack & out_free);
  assign load_instr = skid_pop ? skid_instr : imem.imem_rdata;
  assign load_pc    = skid_pop ? skid_pc : pc;
  assign fetch_gate = ~skid_valid;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .pop      (skid_pop),
    .flush    (redirect_valid),
    .in_instr (imem.imem_rdata),
    .in_pc    (pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );
`else
  assign load_out   = fetch_ack;
  assign load_instr = imem.imem_rdata;
  assign load_pc    = pc;
  assign fetch_gate = ~(if_valid & stall);
`endif

  assign imem.imem_addr = pc;

  always_comb begin
    imem.imem_req = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:   imem.imem_req = fetch_gate;
        DRAIN:   imem.imem_req = 1'b1;
        default: imem.imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      drain_pc    <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus2 <= PC_INC;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      halted   <= 1'b0;
      drain_pc <= redirect_pc;
      // An unacked request keeps its address on the bus until memory answers.
      if (mem_ack || !imem.imem_req) begin
        state <= FETCH;
        pc    <= redirect_pc;
      end else begin
        state <= DRAIN;
      end
    end else begin
      case (state)
        FETCH: begin
          if (fetch_ack) begin
            pc <= pc + PC_INC;
            if (is_halt(imem.imem_rdata)) state <= HALT;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state <= FETCH;
            pc    <= drain_pc;
          end
        end
        default: ;
      endcase

      if (load_out) begin
        if_valid    <= 1'b1;
        if_instr    <= load_instr;
        if_pc       <= load_pc;
        if_pc_plus2 <= load_pc + PC_INC;
      end else if (transfer) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end

      if ((state == HALT) && transfer && is_halt(if_instr)) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a wait-state imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;

  int unsigned wait_cycles = 0;
  int unsigned wcnt = 0;
  int          tests_run;
  int          tests_failed;

  logic [15:0] exp_i [3] = '{16'hc010, 16'hc101, 16'hd828};

  fetch_stage_if mem ();

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (mem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hc010;
      16'h0002: return 16'hc101;
      16'h0004: return 16'hd828;
      16'h0008: return 16'h0000;
      default:  return 16'h8800 | a;
    endcase
  endfunction

  // Ack after wait_cycles consecutive request cycles; a dropped request restarts.
  always_comb begin
    mem.imem_ack   = mem.imem_req && (wcnt == wait_cycles);
    mem.imem_rdata = mem.imem_ack ? mem_word(mem.imem_addr) : 16'hdead;
  end

  always @(posedge clk) begin
    if (!mem.imem_req || mem.imem_ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned w);
    wait_cycles    = w;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    rst            = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    wait_cycles = 0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    rst = 1'b1;
    tick(2);
    tests_run++; if (mem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", mem.imem_req); end
    tests_run++; if (mem.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0000", mem.imem_addr); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    tests_run++; if (if_instr !== 16'h0800) begin tests_failed++; $display("FAIL reset_instr: got %h expected 0800", if_instr); end
    tests_run++; if (if_pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc: got %h expected 0000", if_pc); end
    tests_run++; if (if_pc_plus2 !== 16'h0002) begin tests_failed++; $display("FAIL reset_pc_plus2: got %h expected 0002", if_pc_plus2); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst = 1'b0;
    #1;
    tests_run++; if (mem.imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b expected 1", mem.imem_req); end
    tests_run++; if (mem.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL first_addr: got %h expected 0000", mem.imem_addr); end
  endtask

  task automatic test_stream;
    logic [15:0] ep;
    do_reset(0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      ep = 16'(2 * k);
      tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, if_valid); end
      tests_run++; if (if_instr !== exp_i[k]) begin tests_failed++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, if_instr, exp_i[k]); end
      tests_run++; if (if_pc !== ep) begin tests_failed++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, if_pc, ep); end
      tests_run++; if (if_pc_plus2 !== ep + 16'd2) begin tests_failed++; $display("FAIL stream_pc_plus2[%0d]: got %h expected %h", k, if_pc_plus2, ep + 16'd2); end
    end
  endtask

  task automatic test_wait;
    logic [15:0] ea;
    logic        ev;
    do_reset(3);
    for (int k = 0; k <= 12; k++) begin
      ea = 16'(2 * (k / 4));
      ev = (k > 0) && (k % 4 == 0);
      tests_run++; if (mem.imem_addr !== ea) begin tests_failed++; $display("FAIL wait_addr[C%0d]: got %h expected %h", k, mem.imem_addr, ea); end
      tests_run++; if (mem.imem_req !== 1'b1) begin tests_failed++; $display("FAIL wait_req[C%0d]: got %b expected 1", k, mem.imem_req); end
      tests_run++; if (if_valid !== ev) begin tests_failed++; $display("FAIL wait_valid[C%0d]: got %b expected %b", k, if_valid, ev); end
      if (ev) begin
        tests_run++; if (if_instr !== exp_i[k/4-1]) begin tests_failed++; $display("FAIL wait_instr[C%0d]: got %h expected %h", k, if_instr, exp_i[k/4-1]); end
      end
      if (k < 12) tick(1);
    end
  endtask

  task automatic test_stall;
    do_reset(1);
    tick(4);
    stall = 1'b1;
    for (int k = 4; k <= 6; k++) begin
      if (k == 6) stall = 1'b0;
      tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'hc101) begin tests_failed++; $display("FAIL stall_hold[C%0d]: got %b/%h expected 1/c101", k, if_valid, if_instr); end
      tests_run++; if (if_pc !== 16'h0002) begin tests_failed++; $display("FAIL stall_hold_pc[C%0d]: got %h expected 0002", k, if_pc); end
      tick(1);
    end
`ifdef FETCH_SKID_EN
    tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'hd828) begin tests_failed++; $display("FAIL stall_next[C7]: got %b/%h expected 1/d828", if_valid, if_instr); end
    tests_run++; if (if_pc !== 16'h0004) begin tests_failed++; $display("FAIL stall_next_pc[C7]: got %h expected 0004", if_pc); end
    tick(1);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_after[C8]: got %b expected 0", if_valid); end
`else
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_bubble[C7]: got %b expected 0", if_valid); end
    tick(1);
    tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'hd828) begin tests_failed++; $display("FAIL stall_next[C8]: got %b/%h expected 1/d828", if_valid, if_instr); end
    tests_run++; if (if_pc !== 16'h0004) begin tests_failed++; $display("FAIL stall_next_pc[C8]: got %h expected 0004", if_pc); end
`endif
  endtask

  task automatic test_redirect;
    logic [15:0] ea;
    do_reset(3);
    tick(12);
    tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'hd828) begin tests_failed++; $display("FAIL redir_pre: got %b/%h expected 1/d828", if_valid, if_instr); end
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick(1);
    redirect_valid = 1'b0;
    for (int k = 14; k <= 20; k++) begin
      ea = (k <= 15) ? 16'h0006 : ((k <= 19) ? 16'h0040 : 16'h0042);
      tests_run++; if (mem.imem_addr !== ea) begin tests_failed++; $display("FAIL redir_addr[C%0d]: got %h expected %h", k, mem.imem_addr, ea); end
      tests_run++; if (mem.imem_req !== 1'b1) begin tests_failed++; $display("FAIL redir_req[C%0d]: got %b expected 1", k, mem.imem_req); end
      tests_run++; if (if_valid !== (k == 20)) begin tests_failed++; $display("FAIL redir_valid[C%0d]: got %b expected %b", k, if_valid, (k == 20)); end
      if (k < 20) tick(1);
    end
    tests_run++; if (if_instr !== 16'h8840 || if_pc !== 16'h0040) begin tests_failed++; $display("FAIL redir_target: got %h@%h expected 8840@0040", if_instr, if_pc); end
  endtask

  task automatic test_halt;
    do_reset(0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0008;
    tick(1);
    redirect_valid = 1'b0;
    tests_run++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0008) begin tests_failed++; $display("FAIL halt_fetch: got %b/%h expected 1/0008", mem.imem_req, mem.imem_addr); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_redir_valid: got %b expected 0", if_valid); end
    tick(1);
    tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'h0000 || if_pc !== 16'h0008) begin tests_failed++; $display("FAIL halt_deliver: got %b/%h@%h expected 1/0000@0008", if_valid, if_instr, if_pc); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_early: got %b expected 0", halted); end
    tests_run++; if (mem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL halt_req[C2]: got %b expected 0", mem.imem_req); end
    for (int k = 3; k <= 5; k++) begin
      tick(1);
      tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_flag[C%0d]: got %b expected 1", k, halted); end
      tests_run++; if (mem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL halt_req[C%0d]: got %b expected 0", k, mem.imem_req); end
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_valid[C%0d]: got %b expected 0", k, if_valid); end
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    tick(1);
    redirect_valid = 1'b0;
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL resume_halted: got %b expected 0", halted); end
    tests_run++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL resume_req: got %b/%h expected 1/0000", mem.imem_req, mem.imem_addr); end
    tick(1);
    tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'hc010) begin tests_failed++; $display("FAIL resume_instr: got %b/%h expected 1/c010", if_valid, if_instr); end
  endtask

  task automatic test_wrap;
    do_reset(0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hfffe;
    tick(1);
    redirect_valid = 1'b0;
    tests_run++; if (mem.imem_addr !== 16'hfffe) begin tests_failed++; $display("FAIL wrap_addr: got %h expected fffe", mem.imem_addr); end
    tick(1);
    tests_run++; if (if_instr !== 16'hfffe || if_pc !== 16'hfffe) begin tests_failed++; $display("FAIL wrap_instr: got %h@%h expected fffe@fffe", if_instr, if_pc); end
    tests_run++; if (if_pc_plus2 !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pc_plus2: got %h expected 0000", if_pc_plus2); end
    tests_run++; if (mem.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL wrap_next_addr: got %h expected 0000", mem.imem_addr); end
  endtask

  task automatic test_rst_mid;
    do_reset(3);
    tick(10);
    tests_run++; if (mem.imem_addr !== 16'h0004 || if_pc !== 16'h0002) begin tests_failed++; $display("FAIL rstmid_pre: got %h/%h expected 0004/0002", mem.imem_addr, if_pc); end
    rst = 1'b1;
    tick(1);
    tests_run++; if (mem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req: got %b expected 0", mem.imem_req); end
    tests_run++; if (mem.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_addr: got %h expected 0000", mem.imem_addr); end
    tests_run++; if (if_valid !== 1'b0 || if_instr !== 16'h0800) begin tests_failed++; $display("FAIL rstmid_out: got %b/%h expected 0/0800", if_valid, if_instr); end
    tests_run++; if (if_pc !== 16'h0000 || if_pc_plus2 !== 16'h0002) begin tests_failed++; $display("FAIL rstmid_pc: got %h/%h expected 0000/0002", if_pc, if_pc_plus2); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL rstmid_halted: got %b expected 0", halted); end
    rst = 1'b0;
    #1;
    tests_run++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_first: got %b/%h expected 1/0000", mem.imem_req, mem.imem_addr); end
    tick(4);
    tests_run++; if (if_valid !== 1'b1 || if_instr !== 16'hc010 || if_pc !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_refetch: got %b/%h@%h expected 1/c010@0000", if_valid, if_instr, if_pc); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    test_reset;
    test_stream;
    test_wait;
    test_stall;
    test_redirect;
    test_halt;
    test_wrap;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
